fp_norm_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer that shares the single fp_normalizer instance between the FP adder
//  (requester 0) and FP multiplier (requester 1). Accepts one pre-normalization result per transaction,

---
 rtl/fp_norm_arbiter.sv | 141 ++++++++++++++
 tb/tb_fp_norm_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_norm_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational fp_normalizer between
// the FP adder (requester 0) and FP multiplier (requester 1).
module fp_norm_arbiter #(
  parameter int unsigned MANT_W = 25,
  parameter int unsigned EXP_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [MANT_W-1:0] req0_mant,
  input  logic [EXP_W-1:0]  req0_exp,
  input  logic              req0_sign,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [MANT_W-1:0] req1_mant,
  input  logic [EXP_W-1:0]  req1_exp,
  input  logic              req1_sign,
  output logic [MANT_W-1:0] norm_mant_in,
  output logic [EXP_W-1:0]  norm_exp_in,
  input  logic [MANT_W-3:0] norm_mant_out,
  input  logic [EXP_W-1:0]  norm_exp_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [MANT_W-3:0] res_mant,
  output logic [EXP_W-1:0]  res_exp,
  output logic              res_sign,
  output logic              res_src,
  output logic              res_zero
);

  localparam int unsigned NMANT_W = MANT_W - 2;

  typedef enum logic [1:0] {IDLE, NORM, HOLD} state_t;

  state_t              state_q, state_d;
  logic [MANT_W-1:0]   op_mant_q, op_mant_d;
  logic [EXP_W-1:0]    op_exp_q, op_exp_d;
  logic                op_sign_q, op_sign_d;
  logic                op_src_q, op_src_d;
  logic                last_grant_q, last_grant_d;
  logic                res_valid_q, res_valid_d;
  logic [NMANT_W-1:0]  res_mant_q, res_mant_d;
  logic [EXP_W-1:0]    res_exp_q, res_exp_d;
  logic                res_sign_q, res_sign_d;
  logic                res_src_q, res_src_d;
  logic                res_zero_q, res_zero_d;
  logic                grant1_c;
  logic                idle_c;

  // Requester 1 wins when alone, or on a tie when requester 0 was served last.
  assign grant1_c   = req1_valid & (~req0_valid | ~last_grant_q);
  assign idle_c     = (state_q == IDLE);
  assign req0_ready = idle_c & req0_valid & ~grant1_c;
  assign req1_ready = idle_c & grant1_c;

  assign norm_mant_in = op_mant_q;
  assign norm_exp_in  = op_exp_q;

  assign res_valid = res_valid_q;
  assign res_mant  = res_mant_q;
  assign res_exp   = res_exp_q;
  assign res_sign  = res_sign_q;
  assign res_src   = res_src_q;
  assign res_zero  = res_zero_q;

  // Next-state and next-register values.
  always_comb begin
    state_d      = state_q;
    op_mant_d    = op_mant_q;
    op_exp_d     = op_exp_q;
    op_sign_d    = op_sign_q;
    op_src_d     = op_src_q;
    last_grant_d = last_grant_q;
    res_valid_d  = res_valid_q;
    res_mant_d   = res_mant_q;
    res_exp_d    = res_exp_q;
    res_sign_d   = res_sign_q;
    res_src_d    = res_src_q;
    res_zero_d   = res_zero_q;
    case (state_q)
      IDLE: begin
        if (req0_ready | req1_ready) begin
          op_mant_d    = grant1_c ? req1_mant : req0_mant;
          op_exp_d     = grant1_c ? req1_exp  : req0_exp;
          op_sign_d    = grant1_c ? req1_sign : req0_sign;
          op_src_d     = grant1_c;
          last_grant_d = grant1_c;
          state_d      = NORM;
        end
      end
      NORM: begin
        res_mant_d  = norm_mant_out;
        res_exp_d   = norm_exp_out;
        res_sign_d  = op_sign_q;
        res_src_d   = op_src_q;
        res_zero_d  = (op_mant_q == '0);
        res_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      op_mant_q    <= '0;
      op_exp_q     <= '0;
      op_sign_q    <= 1'b0;
      op_src_q     <= 1'b0;
      last_grant_q <= 1'b1;
      res_valid_q  <= 1'b0;
      res_mant_q   <= '0;
      res_exp_q    <= '0;
      res_sign_q   <= 1'b0;
      res_src_q    <= 1'b0;
      res_zero_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_mant_q    <= op_mant_d;
      op_exp_q     <= op_exp_d;
      op_sign_q    <= op_sign_d;
      op_src_q     <= op_src_d;
      last_grant_q <= last_grant_d;
      res_valid_q  <= res_valid_d;
      res_mant_q   <= res_mant_d;
      res_exp_q    <= res_exp_d;
      res_sign_q   <= res_sign_d;
      res_src_q    <= res_src_d;
      res_zero_q   <= res_zero_d;
    end
  end

endmodule

// File: tb/tb_fp_norm_arbiter.sv
// Bench for fp_norm_arbiter: directed steps plus randomized stress against a
// queue-based reference of accepted transactions and a stand-in normalizer.
module tb_fp_norm_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_sign;
  logic [24:0] req0_mant;
  logic [7:0]  req0_exp;
  logic        req1_valid, req1_ready, req1_sign;
  logic [24:0] req1_mant;
  logic [7:0]  req1_exp;
  logic [24:0] norm_mant_in;
  logic [7:0]  norm_exp_in;
  logic [22:0] norm_mant_out;
  logic [7:0]  norm_exp_out;
  logic        res_valid, res_ready, res_sign, res_src, res_zero;
  logic [22:0] res_mant;
  logic [7:0]  res_exp;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fp_norm_arbiter #(.MANT_W(25), .EXP_W(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_mant(req0_mant),
    .req0_exp(req0_exp), .req0_sign(req0_sign),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_mant(req1_mant),
    .req1_exp(req1_exp), .req1_sign(req1_sign),
    .norm_mant_in(norm_mant_in), .norm_exp_in(norm_exp_in),
    .norm_mant_out(norm_mant_out), .norm_exp_out(norm_exp_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_mant(res_mant),
    .res_exp(res_exp), .res_sign(res_sign), .res_src(res_src), .res_zero(res_zero)
  );

  // Stand-in for the shared fp_normalizer: leading-one search and shift.
  function automatic logic [30:0] stub_norm(input logic [24:0] m, input logic [7:0] e);
    int p;
    logic [24:0] s;
    p = 0;
    if (m[24]) return {m[23:1], 8'(e + 8'd1)};
    if (m == '0) return 31'd0;
    for (int i = 0; i < 24; i++) if (m[i]) p = i;
    s = m << (23 - p);
    return {s[22:0], 8'(e - 8'(23 - p))};
  endfunction

  always_comb {norm_mant_out, norm_exp_out} = stub_norm(norm_mant_in, norm_exp_in);

  // Expected {zero, sign, exp, mant} from plain arithmetic on the value.
  function automatic logic [32:0] ref_result(input logic [24:0] m, input logic [7:0] e,
                                             input logic s);
    longint v;
    int x;
    v = longint'(m);
    x = int'(e);
    if (v == 0) return {1'b1, s, 8'd0, 23'd0};
    if (v >= 2**24) begin v = v / 2; x = x + 1; end
    while (v < 2**23) begin v = v * 2; x = x - 1; end
    return {1'b0, s, 8'(x), 23'(v - 2**23)};
  endfunction

  function automatic logic [24:0] rand_mant();
    logic [24:0] m;
    if ($urandom_range(0, 7) == 0) return 25'd0;
    m = 25'($urandom);
    return m >> $urandom_range(0, 24);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // One full transaction on one requester with res_ready asserted in HOLD.
  task automatic do_txn(input logic src, input logic [24:0] m, input logic [7:0] e,
                        input logic s, output logic [32:0] obs);
    int n;
    if (src) begin
      req1_valid = 1'b1; req1_mant = m; req1_exp = e; req1_sign = s;
    end else begin
      req0_valid = 1'b1; req0_mant = m; req0_exp = e; req0_sign = s;
    end
    settle();
    n = 0;
    while (!(src ? req1_ready : req0_ready) && n < 8) begin tick(); settle(); n++; end
    chk("txn_ready", 64'(src ? req1_ready : req0_ready), 64'd1);
    tick();
    if (src) req1_valid = 1'b0; else req0_valid = 1'b0;
    settle();
    chk("txn_norm_valid", 64'(res_valid), 64'd0);
    tick();
    chk("txn_res_valid", 64'(res_valid), 64'd1);
    chk("txn_res_src", 64'(res_src), 64'(src));
    obs = {res_zero, res_sign, res_exp, res_mant};
    res_ready = 1'b1;
    settle();
    tick();
    res_ready = 1'b0;
    chk("txn_released", 64'(res_valid), 64'd0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [32:0] obs;
    logic [32:0] q0[$];
    logic [32:0] q1[$];
    logic pending, last, acc0, acc1;
    int n;

    rst = 1'b1; res_ready = 1'b0;
    req0_valid = 1'b0; req0_mant = '0; req0_exp = '0; req0_sign = 1'b0;
    req1_valid = 1'b0; req1_mant = '0; req1_exp = '0; req1_sign = 1'b0;
    tick(); tick();
    rst = 1'b0;
    settle();

    // Reset state
    chk("rst_res", 64'({res_valid, res_sign, res_src, res_zero, res_exp, res_mant}), 64'd0);
    chk("rst_operand", 64'({norm_mant_in, norm_exp_in}), 64'd0);
    chk("idle_no_req_ready", 64'({req1_ready, req0_ready}), 64'd0);

    // Single adder request, cycle-by-cycle
    req0_valid = 1'b1; req0_mant = 25'h0800000; req0_exp = 8'd100; req0_sign = 1'b1;
    settle();
    chk("t1_ready", 64'({req1_ready, req0_ready}), 64'b01);
    tick();
    req0_valid = 1'b0;
    settle();
    chk("t1_norm_no_valid", 64'(res_valid), 64'd0);
    chk("t1_operand", 64'({norm_mant_in, norm_exp_in}), 64'({25'h0800000, 8'd100}));
    tick();
    chk("t1_valid", 64'(res_valid), 64'd1);
    chk("t1_result", 64'({res_zero, res_sign, res_src, res_exp, res_mant}),
        64'({1'b0, 1'b1, 1'b0, 8'd100, 23'h0}));
    res_ready = 1'b1;
    settle();
    tick();
    res_ready = 1'b0;
    chk("t1_release", 64'(res_valid), 64'd0);

    // Normalizer corner values via multiplier
    do_txn(1'b1, 25'h1000001, 8'd10, 1'b0, obs);
    chk("t3_carry", 64'(obs), 64'({1'b0, 1'b0, 8'd11, 23'h0}));
    do_txn(1'b1, 25'h0000100, 8'd50, 1'b1, obs);
    chk("t3_shift15", 64'(obs), 64'({1'b0, 1'b1, 8'd35, 23'h0}));
    do_txn(1'b1, 25'h0000000, 8'd77, 1'b0, obs);
    chk("t3_zero", 64'(obs), 64'({1'b1, 1'b0, 8'd0, 23'h0}));

    // HOLD with consumer stalled and new requests pending
    req0_valid = 1'b1; req0_mant = 25'h0C00000; req0_exp = 8'd20; req0_sign = 1'b0;
    settle();
    chk("t4_ready", 64'(req0_ready), 64'd1);
    tick();
    req0_valid = 1'b0;
    tick();
    req0_valid = 1'b1; req0_mant = 25'h0123456; req0_exp = 8'd3;
    req1_valid = 1'b1; req1_mant = 25'h1ABCDEF; req1_exp = 8'd200;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("t4_hold_ready", 64'({req1_ready, req0_ready}), 64'd0);
      chk("t4_hold_res", 64'({res_valid, res_zero, res_sign, res_src, res_exp, res_mant}),
          64'({1'b1, 1'b0, 1'b0, 1'b0, 8'd20, 23'h400000}));
      tick();
    end
    res_ready = 1'b1;
    settle();
    tick();
    res_ready = 1'b0;
    settle();
    chk("t4_next_rr", 64'({req1_ready, req0_ready}), 64'b10);

    // Reset in NORM, then in HOLD
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    chk("t5_norm_rst_valid", 64'(res_valid), 64'd0);
    chk("t5_norm_rst_grant", 64'({req1_ready, req0_ready}), 64'b01);
    tick();
    tick();
    chk("t5_hold_reached", 64'(res_valid), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    chk("t5_hold_rst_res", 64'({res_valid, res_sign, res_src, res_zero, res_exp, res_mant}), 64'd0);
    chk("t5_hold_rst_grant", 64'({req1_ready, req0_ready}), 64'b01);

    // Both held valid: grants alternate starting with requester 0
    res_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!(req0_ready | req1_ready) && n < 8) begin tick(); settle(); n++; end
      chk("t2_grant", 64'({req1_ready, req0_ready}), (k % 2 == 0) ? 64'b01 : 64'b10);
      tick();
      settle();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick(); tick(); tick();
    res_ready = 1'b0;

    // Randomized stress against the accepted-transaction queues
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pending = 1'b0;
    last = 1'b1;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (cyc >= 1480) begin
        req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
      end else begin
        if (!req0_valid) begin
          if ($urandom_range(0, 2) == 0) begin
            req0_valid = 1'b1; req0_mant = rand_mant(); req0_exp = 8'($urandom);
            req0_sign = 1'($urandom);
          end
        end else if ($urandom_range(0, 15) == 0) req0_valid = 1'b0;
        if (!req1_valid) begin
          if ($urandom_range(0, 2) == 0) begin
            req1_valid = 1'b1; req1_mant = rand_mant(); req1_exp = 8'($urandom);
            req1_sign = 1'($urandom);
          end
        end else if ($urandom_range(0, 15) == 0) req1_valid = 1'b0;
        res_ready = 1'($urandom);
      end
      settle();
      chk("s_excl", 64'(req0_ready & req1_ready), 64'd0);
      if (pending)
        chk("s_busy", 64'({req1_ready, req0_ready}), 64'd0);
      else if (req0_valid & req1_valid)
        chk("s_rr", 64'({req1_ready, req0_ready}), last ? 64'b01 : 64'b10);
      else if (req0_valid | req1_valid)
        chk("s_single", 64'({req1_ready, req0_ready}), 64'({req1_valid, req0_valid}));
      if (res_valid & res_ready) begin
        obs = {res_zero, res_sign, res_exp, res_mant};
        if (res_src) begin
          chk("s_src1_expected", 64'(q1.size() != 0), 64'd1);
          if (q1.size() != 0) chk("s_res1", 64'(obs), 64'(q1.pop_front()));
        end else begin
          chk("s_src0_expected", 64'(q0.size() != 0), 64'd1);
          if (q0.size() != 0) chk("s_res0", 64'(obs), 64'(q0.pop_front()));
        end
        pending = 1'b0;
      end
      acc0 = req0_valid & req0_ready;
      acc1 = req1_valid & req1_ready;
      if (acc0) begin
        q0.push_back(ref_result(req0_mant, req0_exp, req0_sign));
        pending = 1'b1; last = 1'b0;
      end
      if (acc1) begin
        q1.push_back(ref_result(req1_mant, req1_exp, req1_sign));
        pending = 1'b1; last = 1'b1;
      end
      tick();
      if (acc0) req0_valid = 1'b0;
      if (acc1) req1_valid = 1'b0;
    end
    chk("s_drain_q0", 64'(q0.size()), 64'd0);
    chk("s_drain_q1", 64'(q1.size()), 64'd0);
    chk("s_drain_valid", 64'(res_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
